vga_sync_checker: RTL
=====================

VGA_SYNC_CHECKER -- requirements
Module: vga_sync_checker

Interface
REQ-001 Parameter H_TOTAL, default 1056, pclk cycles per line.
REQ-002 Parameter H_SYNC, default 128, hs pulse width in pclk cycles.
REQ-003 Parameter V_TOTAL, default 628, lines per frame.
REQ-004 Parameter V_SYNC, default 4, vs pulse width in lines.
REQ-005 Parameter SYNC_POL, default 1, active level of hs and vs (1 = active-high).
REQ-006 pclk  input  1  pixel clock; the only clock; all logic is on its rising edge.
REQ-007 rst_n  input  1  reset, synchronous, active-low.
REQ-008 hs  input  1  horizontal sync from the VGA pipeline.
REQ-009 vs  input  1  vertical sync from the VGA pipeline.
REQ-010 r, g, b  input  4 each  pixel colour from the VGA pipeline.
REQ-011 clr  input  1  synchronous pulse that clears the sticky error flags.
REQ-012 locked  output  1  stream timing matches the parameters.
REQ-013 err_hs_period, err_hs_width, err_vs_period, err_vs_width, err_rgb  output  1 each  sticky error flags.
REQ-014 frame_cnt  output  16  count of vs leading edges since reset.

Function
REQ-015 hs, vs, r, g and b shall be registered once (stage 1); edges shall be detected by comparing stage 1 against a delayed copy (stage 2).
REQ-016 Leading edge means a transition into SYNC_POL; trailing edge means a transition out of SYNC_POL.
REQ-017 All outputs shall be registered; a flag shall rise on the 2nd pclk edge after the offending sample is present on the inputs.
REQ-018 hcnt (12 bit) shall count pclk cycles since the last hs leading edge, reload to 1 on each hs leading edge, and saturate at 4095.
REQ-019 On an hs leading edge with a previous edge seen since SEARCH was left, hcnt != H_TOTAL shall set err_hs_period.
REQ-020 On an hs trailing edge, a measured hs active length != H_SYNC cycles shall set err_hs_width.
REQ-021 vcnt (11 bit) shall count hs leading edges since the last vs leading edge, and saturate at 2047.
REQ-022 On a vs leading edge other than the first after SEARCH, vcnt != V_TOTAL shall set err_vs_period.
REQ-023 On a vs trailing edge, a count of hs leading edges during vs active != V_SYNC shall set err_vs_width.
REQ-024 Any nonzero r, g or b sampled while hs or vs is active shall set err_rgb.
REQ-025 An error flag, once set, shall hold until a clr sample is taken.
REQ-026 If clr and a new error event occur in the same cycle, the flag shall be 1 (set wins).
REQ-027 frame_cnt shall increment on every vs leading edge and wrap from 0xFFFF to 0.
REQ-028 The FSM shall have states SEARCH, MEASURE and LOCKED.
REQ-029 SEARCH shall go to MEASURE on the first vs leading edge.
REQ-030 In MEASURE, a good_cnt shall count frames ending at a vs leading edge with no error event in that frame; any error event shall clear good_cnt.
REQ-031 MEASURE shall go to LOCKED when good_cnt reaches 2.
REQ-032 In LOCKED, any period or width error event shall return the FSM to SEARCH and clear the counters.
REQ-033 locked shall be 1 only in LOCKED; it shall fall one cycle after the error event is detected.
REQ-034 A clr in any state shall not change the FSM state.
REQ-035 An rgb error shall set err_rgb only and shall not affect lock.

Reset
REQ-036 While rst_n = 0 at a pclk edge, the block shall load state SEARCH, clear hcnt, vcnt, good_cnt and the pipeline registers, and set every output to 0.
REQ-037 A reset asserted mid-frame shall take effect at the next pclk edge, regardless of FSM state.
REQ-038 After reset is released, no period error shall be flagged until a reference edge has been captured (REQ-019 and REQ-022).

Verification
REQ-039 Nominal 1056x628 stream, hs 128 clk, vs 4 lines, rgb 0 in sync, 3 vs leading edges -> locked = 1 after the 3rd edge, frame_cnt = 3, all err = 0.
REQ-040 Locked stream, then one line of 1055 clk -> err_hs_period = 1, locked = 0 within 3 clk, relock after 3 further clean vs leading edges.
REQ-041 hs pulse of 127 clk on one line -> err_hs_width = 1, all other flags 0.
REQ-042 r = 4'h1 for one pixel during an hs pulse -> err_rgb = 1, locked unchanged.
REQ-043 clr in the same cycle as a vs-width error event -> err_vs_width = 1; clr alone later -> all flags 0, frame_cnt unchanged.
REQ-044 rst_n = 0 for 1 clk mid-frame while locked -> next edge all outputs 0, FSM in SEARCH; relock after 3 clean vs leading edges.

Source files
------------

// File: rtl/vga_sync_checker_if.sv
// VGA stream bundle: sync pulses and 4-bit colour channels seen by the timing checker.
// The pipeline drives it through master; the checker observes it through slave.
interface vga_sync_checker_if;
    logic       hs;
    logic       vs;
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;

    modport master (output hs, vs, r, g, b);
    modport slave  (input  hs, vs, r, g, b);
endinterface

// File: rtl/vga_sync_checker.sv
// Passive VGA timing monitor: measures hs/vs period and width, flags blanking colour
// violations, and reports lock once two consecutive clean frames have been observed.
//
// state   | meaning
// --------+-------------------------------------------------------------
// SEARCH  | no frame reference yet; waiting for the first vs leading edge
// MEASURE | frame reference held; counting consecutive clean frames
// LOCKED  | stream matches the configured timing; any timing error drops lock
module vga_sync_checker #(
    parameter int H_TOTAL  = 1056,
    parameter int H_SYNC   = 128,
    parameter int V_TOTAL  = 628,
    parameter int V_SYNC   = 4,
    parameter bit SYNC_POL = 1'b1
) (
    input  logic                 pclk,
    input  logic                 rst_n,
    vga_sync_checker_if.slave    vga,
    input  logic                 clr,
    output logic                 locked,
    output logic                 err_hs_period,
    output logic                 err_hs_width,
    output logic                 err_vs_period,
    output logic                 err_vs_width,
    output logic                 err_rgb,
    output logic [15:0]          frame_cnt
);

    localparam logic [11:0] H_TOTAL_C = 12'(H_TOTAL);
    localparam logic [11:0] H_SYNC_C  = 12'(H_SYNC);
    localparam logic [10:0] V_TOTAL_C = 11'(V_TOTAL);
    localparam logic [10:0] V_SYNC_C  = 11'(V_SYNC);
    localparam logic [11:0] HCNT_MAX  = 12'hFFF;
    localparam logic [10:0] VCNT_MAX  = 11'h7FF;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t      state_q, state_d;

    logic        s1_hs_q, s1_vs_q, s2_hs_q, s2_vs_q;
    logic [3:0]  s1_r_q, s1_g_q, s1_b_q;

    logic [11:0] hcnt_q, hcnt_d;
    logic [10:0] vcnt_q, vcnt_d;
    logic [10:0] vsw_cnt_q, vsw_cnt_d;
    logic [1:0]  good_cnt_q, good_cnt_d;
    logic        hs_seen_q, hs_seen_d;
    logic        vs_seen_q, vs_seen_d;
    logic        h_ref_q, h_ref_d;
    logic        v_ref_q, v_ref_d;
    logic        frame_err_q, frame_err_d;

    logic        locked_q, locked_d;
    logic        err_hs_period_q, err_hs_period_d;
    logic        err_hs_width_q, err_hs_width_d;
    logic        err_vs_period_q, err_vs_period_d;
    logic        err_vs_width_q, err_vs_width_d;
    logic        err_rgb_q, err_rgb_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;

    logic        hs_act1, hs_act2, vs_act1, vs_act2;
    logic        hs_lead, hs_trail, vs_lead, vs_trail;
    logic        ev_hs_period, ev_hs_width, ev_vs_period, ev_vs_width, ev_rgb;
    logic        ev_timing;
    logic        abort;

    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            s1_hs_q <= 1'b0;
            s1_vs_q <= 1'b0;
            s1_r_q  <= 4'h0;
            s1_g_q  <= 4'h0;
            s1_b_q  <= 4'h0;
            s2_hs_q <= 1'b0;
            s2_vs_q <= 1'b0;
        end else begin
            s1_hs_q <= vga.hs;
            s1_vs_q <= vga.vs;
            s1_r_q  <= vga.r;
            s1_g_q  <= vga.g;
            s1_b_q  <= vga.b;
            s2_hs_q <= s1_hs_q;
            s2_vs_q <= s1_vs_q;
        end
    end

    assign hs_act1  = (s1_hs_q == SYNC_POL);
    assign hs_act2  = (s2_hs_q == SYNC_POL);
    assign vs_act1  = (s1_vs_q == SYNC_POL);
    assign vs_act2  = (s2_vs_q == SYNC_POL);
    assign hs_lead  = hs_act1 & ~hs_act2;
    assign hs_trail = ~hs_act1 & hs_act2;
    assign vs_lead  = vs_act1 & ~vs_act2;
    assign vs_trail = ~vs_act1 & vs_act2;

    // Width checks need a leading edge since reset, otherwise a pulse cut by reset is measured.
    assign ev_hs_period = hs_lead & h_ref_q & (hcnt_q != H_TOTAL_C);
    assign ev_hs_width  = hs_trail & hs_seen_q & (hcnt_q != H_SYNC_C);
    assign ev_vs_period = vs_lead & v_ref_q & (vcnt_q != V_TOTAL_C);
    assign ev_vs_width  = vs_trail & vs_seen_q & (vsw_cnt_q != V_SYNC_C);
    assign ev_rgb       = (|{s1_r_q, s1_g_q, s1_b_q}) & (hs_act1 | vs_act1);
    assign ev_timing    = ev_hs_period | ev_hs_width | ev_vs_period | ev_vs_width;

    always_comb begin
        hcnt_d    = hcnt_q;
        vcnt_d    = vcnt_q;
        vsw_cnt_d = vsw_cnt_q;
        hs_seen_d = hs_seen_q | hs_lead;
        vs_seen_d = vs_seen_q | vs_lead;

        if (hs_lead) begin
            hcnt_d = 12'd1;
        end else if (hcnt_q != HCNT_MAX) begin
            hcnt_d = hcnt_q + 12'd1;
        end

        // An hs edge coincident with the vs edge is the first line of the new frame.
        if (vs_lead) begin
            vcnt_d    = hs_lead ? 11'd1 : 11'd0;
            vsw_cnt_d = hs_lead ? 11'd1 : 11'd0;
        end else if (hs_lead) begin
            if (vcnt_q != VCNT_MAX) begin
                vcnt_d = vcnt_q + 11'd1;
            end
            if (vs_act1 && (vsw_cnt_q != VCNT_MAX)) begin
                vsw_cnt_d = vsw_cnt_q + 11'd1;
            end
        end

        if (abort) begin
            vcnt_d = 11'd0;
        end
    end

    always_comb begin
        state_d     = state_q;
        good_cnt_d  = good_cnt_q;
        frame_err_d = frame_err_q | ev_timing;
        abort       = 1'b0;

        case (state_q)
            SEARCH: begin
                good_cnt_d  = 2'd0;
                frame_err_d = 1'b0;
                if (vs_lead) begin
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                if (ev_timing) begin
                    good_cnt_d = 2'd0;
                end
                // An error on the closing vs edge still belongs to the frame it closes.
                if (vs_lead) begin
                    frame_err_d = 1'b0;
                    if (!frame_err_q && !ev_timing) begin
                        if (good_cnt_q == 2'd1) begin
                            good_cnt_d = 2'd2;
                            state_d    = LOCKED;
                        end else begin
                            good_cnt_d = good_cnt_q + 2'd1;
                        end
                    end
                end
            end
            LOCKED: begin
                if (ev_timing) begin
                    state_d    = SEARCH;
                    good_cnt_d = 2'd0;
                    abort      = 1'b1;
                end
            end
            default: begin
                state_d    = SEARCH;
                good_cnt_d = 2'd0;
            end
        endcase

        if (state_d == SEARCH) begin
            h_ref_d = 1'b0;
            v_ref_d = 1'b0;
        end else begin
            h_ref_d = h_ref_q | hs_lead;
            v_ref_d = v_ref_q | vs_lead;
        end
    end

    always_comb begin
        locked_d        = (state_d == LOCKED);
        err_hs_period_d = ev_hs_period | (err_hs_period_q & ~clr);
        err_hs_width_d  = ev_hs_width  | (err_hs_width_q  & ~clr);
        err_vs_period_d = ev_vs_period | (err_vs_period_q & ~clr);
        err_vs_width_d  = ev_vs_width  | (err_vs_width_q  & ~clr);
        err_rgb_d       = ev_rgb       | (err_rgb_q       & ~clr);
        frame_cnt_d     = frame_cnt_q + {15'd0, vs_lead};
    end

    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            state_q         <= SEARCH;
            hcnt_q          <= 12'd0;
            vcnt_q          <= 11'd0;
            vsw_cnt_q       <= 11'd0;
            good_cnt_q      <= 2'd0;
            hs_seen_q       <= 1'b0;
            vs_seen_q       <= 1'b0;
            h_ref_q         <= 1'b0;
            v_ref_q         <= 1'b0;
            frame_err_q     <= 1'b0;
            locked_q        <= 1'b0;
            err_hs_period_q <= 1'b0;
            err_hs_width_q  <= 1'b0;
            err_vs_period_q <= 1'b0;
            err_vs_width_q  <= 1'b0;
            err_rgb_q       <= 1'b0;
            frame_cnt_q     <= 16'd0;
        end else begin
            state_q         <= state_d;
            hcnt_q          <= hcnt_d;
            vcnt_q          <= vcnt_d;
            vsw_cnt_q       <= vsw_cnt_d;
            good_cnt_q      <= good_cnt_d;
            hs_seen_q       <= hs_seen_d;
            vs_seen_q       <= vs_seen_d;
            h_ref_q         <= h_ref_d;
            v_ref_q         <= v_ref_d;
            frame_err_q     <= frame_err_d;
            locked_q        <= locked_d;
            err_hs_period_q <= err_hs_period_d;
            err_hs_width_q  <= err_hs_width_d;
            err_vs_period_q <= err_vs_period_d;
            err_vs_width_q  <= err_vs_width_d;
            err_rgb_q       <= err_rgb_d;
            frame_cnt_q     <= frame_cnt_d;
        end
    end

    assign locked        = locked_q;
    assign err_hs_period = err_hs_period_q;
    assign err_hs_width  = err_hs_width_q;
    assign err_vs_period = err_vs_period_q;
    assign err_vs_width  = err_vs_width_q;
    assign err_rgb       = err_rgb_q;
    assign frame_cnt     = frame_cnt_q;

endmodule
